// File: rtl/capture_ctrl_pkg.sv
// Shared types and sizing for the trace capture controller.
package capture_pkg;

  localparam int ENTRIES   = 512;
  localparam int ADDR_W    = $clog2(ENTRIES);
  localparam int DEC_W     = 4;
  localparam int DEC_CNT_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    PRETRIG,
    ARMED,
    POSTTRIG,
    DONE,
    DUMP
  } state_t;

  // Low 'e' bits set; a tick fires when all of them are set in the counter.
  function automatic logic [DEC_CNT_W-1:0] dec_mask(input int unsigned e);
    return (DEC_CNT_W'(1) << e) - 1'b1;
  endfunction

endpackage

// File: rtl/capture_ctrl_if.sv
// Command/trigger/UART side and RAM side of the capture controller.
interface capture_ctrl_if #(
  parameter int ADDR_W = capture_pkg::ADDR_W,
  parameter int DEC_W  = capture_pkg::DEC_W
);
  logic              cap_start;
  logic [ADDR_W-1:0] trig_pos;
  logic [DEC_W-1:0]  decimator;
  logic              trig;
  logic              dump_req;
  logic              tx_done;
  logic              we;
  logic              cap_en;
  logic [ADDR_W-1:0] cap_addr;
  logic [ADDR_W-1:0] trace_end;
  logic              dump_en;
  logic              armed;
  logic              capture_done;
  logic              dump_done;

  modport master (
    output cap_start, trig_pos, decimator, trig, dump_req, tx_done,
    input  we, cap_en, cap_addr, trace_end, dump_en, armed, capture_done, dump_done
  );

  modport slave (
    input  cap_start, trig_pos, decimator, trig, dump_req, tx_done,
    output we, cap_en, cap_addr, trace_end, dump_en, armed, capture_done, dump_done
  );
endinterface

// File: rtl/capture_ctrl_sample_timer.sv
// Decimating sample-tick generator; counter restarts whenever run drops.
module sample_timer #(
  parameter int DEC_W = capture_pkg::DEC_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [DEC_W-1:0] dec_q,
  output logic             tick
);
  import capture_pkg::*;

  logic [DEC_CNT_W-1:0] cnt_q, cnt_d, mask;

  always_comb begin
    mask  = dec_mask(32'(dec_q));
    cnt_d = run ? cnt_q + 1'b1 : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tick = run && ((cnt_q & mask) == mask);

endmodule

// File: rtl/capture_ctrl.sv
// Capture/dump sequencer for a circular trace buffer: pre-trigger fill,
// trigger window, post-trigger count, then one full-trace UART dump.
module capture_ctrl #(
  parameter int ENTRIES = capture_pkg::ENTRIES,
  parameter int ADDR_W  = capture_pkg::ADDR_W,
  parameter int DEC_W   = capture_pkg::DEC_W
) (
  input logic           clk,
  input logic           rst_n,
  capture_ctrl_if.slave bus
);
  import capture_pkg::*;

  localparam int CNT_W = ADDR_W + 1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] tp_q, tp_d;
  logic [DEC_W-1:0]  dec_q, dec_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [CNT_W-1:0]  scnt_q, scnt_d, scnt_inc, pre_need;
  logic [ADDR_W-1:0] post_q, post_d;
  logic [ADDR_W-1:0] tx_q, tx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] tend_q, tend_d;
  logic              we_q, we_d;
  logic              dump_done_q, dump_done_d;
  logic              armed_q, capture_done_q, dump_en_q;
  logic              run, tick;

  assign run = state_q inside {PRETRIG, ARMED, POSTTRIG};

  sample_timer #(.DEC_W(DEC_W)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (run),
    .dec_q (dec_q),
    .tick  (tick)
  );

  always_comb begin
    state_d     = state_q;
    tp_d        = tp_q;
    dec_d       = dec_q;
    wptr_d      = wptr_q;
    scnt_d      = scnt_q;
    post_d      = post_q;
    tx_d        = tx_q;
    addr_d      = addr_q;
    tend_d      = tend_q;
    we_d        = 1'b0;
    dump_done_d = 1'b0;
    scnt_inc    = (scnt_q == CNT_W'(ENTRIES)) ? scnt_q : scnt_q + 1'b1;
    pre_need    = CNT_W'(ENTRIES) - {1'b0, tp_q};

    // tick only fires in the sampling states, so this write path is shared
    if (tick) begin
      we_d   = 1'b1;
      addr_d = wptr_q;
      wptr_d = wptr_q + 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (bus.cap_start) begin
          tp_d    = bus.trig_pos;
          dec_d   = bus.decimator;
          wptr_d  = '0;
          scnt_d  = '0;
          state_d = PRETRIG;
        end
      end
      PRETRIG: begin
        if (tick) begin
          scnt_d = scnt_inc;
          if (scnt_inc >= pre_need) state_d = ARMED;
        end
      end
      ARMED: begin
        if (bus.trig) begin
          post_d = '0;
          if (tp_q == '0) begin
            // a coincident tick is the last pre-trigger sample
            tend_d  = wptr_d - 1'b1;
            state_d = DONE;
          end else begin
            state_d = POSTTRIG;
          end
        end
      end
      POSTTRIG: begin
        if (tick) begin
          post_d = post_q + 1'b1;
          if (post_d == tp_q) begin
            tend_d  = wptr_q;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (bus.dump_req) begin
          tx_d    = '0;
          state_d = DUMP;
        end
      end
      DUMP: begin
        if (bus.tx_done) begin
          tx_d = tx_q + 1'b1;
          if (tx_q == ADDR_W'(ENTRIES - 1)) begin
            dump_done_d = 1'b1;
            state_d     = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      tp_q           <= '0;
      dec_q          <= '0;
      wptr_q         <= '0;
      scnt_q         <= '0;
      post_q         <= '0;
      tx_q           <= '0;
      addr_q         <= '0;
      tend_q         <= '0;
      we_q           <= 1'b0;
      dump_done_q    <= 1'b0;
      armed_q        <= 1'b0;
      capture_done_q <= 1'b0;
      dump_en_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      tp_q           <= tp_d;
      dec_q          <= dec_d;
      wptr_q         <= wptr_d;
      scnt_q         <= scnt_d;
      post_q         <= post_d;
      tx_q           <= tx_d;
      addr_q         <= addr_d;
      tend_q         <= tend_d;
      we_q           <= we_d;
      dump_done_q    <= dump_done_d;
      armed_q        <= (state_d == ARMED);
      capture_done_q <= (state_d == DONE) || (state_d == DUMP);
      dump_en_q      <= (state_d == DUMP);
    end
  end

  assign bus.we           = we_q;
  assign bus.cap_en       = we_q;
  assign bus.cap_addr     = addr_q;
  assign bus.trace_end    = tend_q;
  assign bus.dump_en      = dump_en_q;
  assign bus.armed        = armed_q;
  assign bus.capture_done = capture_done_q;
  assign bus.dump_done    = dump_done_q;

endmodule

// File: tb/tb_capture_ctrl.sv
// Directed bench for capture_ctrl: reset, fill/trigger, decimation, tp=0, dump, ignored commands.
module tb_capture_ctrl;
  import capture_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  capture_ctrl_if bus ();

  capture_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [2*ADDR_W+5:0] outs();
    return {bus.we, bus.cap_en, bus.cap_addr, bus.trace_end, bus.dump_en,
            bus.armed, bus.capture_done, bus.dump_done};
  endfunction

  task automatic idle_inputs();
    bus.cap_start = 1'b0;
    bus.trig_pos  = '0;
    bus.decimator = '0;
    bus.trig      = 1'b0;
    bus.dump_req  = 1'b0;
    bus.tx_done   = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic start_cap(input int tp, input int dec);
    @(negedge clk);
    bus.trig_pos  = ADDR_W'(tp);
    bus.decimator = DEC_W'(dec);
    bus.cap_start = 1'b1;
    @(negedge clk);
    bus.cap_start = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (outs() !== '0) begin
      n_err++; $display("FAIL reset_outputs: got %h want 0", outs());
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (outs() !== '0) begin
      n_err++; $display("FAIL idle_quiet: got %h want 0", outs());
    end
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    start_cap(100, 0);
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (bus.armed) begin seen = 1; break; end
    end
    n_cmp++;
    if (!seen) begin n_err++; $display("FAIL rstmid_armed_timeout: armed got 0 want 1"); end
    bus.trig = 1'b1;
    @(negedge clk);
    bus.trig = 1'b0;
    repeat (5) @(negedge clk);
    n_cmp++;
    if ({bus.we, bus.capture_done} !== 2'b10) begin
      n_err++; $display("FAIL rstmid_posttrig: we/done got %b want 10", {bus.we, bus.capture_done});
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_cmp++;
    if (outs() !== '0) begin
      n_err++; $display("FAIL rstmid_outputs: got %h want 0", outs());
    end
    bus.trig = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if (outs() !== '0) begin
        n_err++; $display("FAIL rstmid_trig_ignored: cycle %0d got %h want 0", i, outs());
      end
    end
    bus.trig = 1'b0;
  endtask

  // trig held high; coincident ARMED tick is the 257th pre-trigger sample
  task automatic test_fill();
    int nwe = 0, gaps = 0;
    bit started = 0, armed_seen = 0, done = 0;
    bus.trig = 1'b1;
    start_cap(256, 0);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (bus.we) begin
        n_cmp++;
        if (bus.cap_addr !== ADDR_W'(nwe)) begin
          n_err++; $display("FAIL fill_addr: write %0d got %0d want %0d", nwe, bus.cap_addr, ADDR_W'(nwe));
        end
        nwe++;
        started = 1;
      end else if (started) gaps++;
      if (bus.armed && !armed_seen) begin
        armed_seen = 1;
        n_cmp++;
        if (nwe != 256) begin n_err++; $display("FAIL fill_armed_at: got %0d want 256", nwe); end
      end
      if (bus.capture_done) begin done = 1; break; end
    end
    bus.trig = 1'b0;
    n_cmp++;
    if (!done) begin n_err++; $display("FAIL fill_timeout: capture_done got 0 want 1"); end
    n_cmp++;
    if (nwe != 513) begin n_err++; $display("FAIL fill_writes: got %0d want 513", nwe); end
    n_cmp++;
    if (gaps != 0) begin n_err++; $display("FAIL fill_we_gaps: got %0d want 0", gaps); end
    n_cmp++;
    if (bus.trace_end !== ADDR_W'(0)) begin
      n_err++; $display("FAIL fill_trace_end: got %0d want 0", bus.trace_end);
    end
    @(negedge clk);
    n_cmp++;
    if ({bus.we, bus.cap_en, bus.armed, bus.capture_done} !== 4'b0001) begin
      n_err++; $display("FAIL fill_done_state: got %b want 0001", {bus.we, bus.cap_en, bus.armed, bus.capture_done});
    end
    do_reset();
  endtask

  task automatic test_decimate();
    int nwe = 0, since = 0;
    bit armed_seen = 0, done = 0;
    start_cap(10, 2);
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      bus.trig = 1'b0;
      since++;
      if (bus.we) begin
        if (nwe > 0) begin
          n_cmp++;
          if (since != 4) begin n_err++; $display("FAIL dec_spacing: write %0d got %0d want 4", nwe, since); end
        end
        n_cmp++;
        if (bus.cap_addr !== ADDR_W'(nwe)) begin
          n_err++; $display("FAIL dec_addr: write %0d got %0d want %0d", nwe, bus.cap_addr, ADDR_W'(nwe));
        end
        nwe++;
        since = 0;
        if (nwe == 600) bus.trig = 1'b1;
      end
      if (bus.armed && !armed_seen) begin
        armed_seen = 1;
        n_cmp++;
        if (nwe != 502) begin n_err++; $display("FAIL dec_armed_at: got %0d want 502", nwe); end
      end
      if (bus.capture_done) begin done = 1; break; end
    end
    bus.trig = 1'b0;
    n_cmp++;
    if (!done) begin n_err++; $display("FAIL dec_timeout: capture_done got 0 want 1"); end
    n_cmp++;
    if (nwe != 610) begin n_err++; $display("FAIL dec_writes: got %0d want 610", nwe); end
    n_cmp++;
    if (bus.trace_end !== ADDR_W'(97)) begin
      n_err++; $display("FAIL dec_trace_end: got %0d want 97", bus.trace_end);
    end
    do_reset();
  endtask

  task automatic test_tp0();
    int nwe = 0;
    bit armed_seen = 0, done = 0;
    start_cap(0, 1);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      bus.trig = 1'b0;
      if (bus.we) begin
        n_cmp++;
        if (bus.cap_addr !== ADDR_W'(nwe)) begin
          n_err++; $display("FAIL tp0_addr: write %0d got %0d want %0d", nwe, bus.cap_addr, ADDR_W'(nwe));
        end
        nwe++;
        if (nwe == 549) bus.trig = 1'b1;
      end
      if (bus.armed && !armed_seen) begin
        armed_seen = 1;
        n_cmp++;
        if (nwe != 512) begin n_err++; $display("FAIL tp0_armed_at: got %0d want 512", nwe); end
      end
      if (bus.capture_done) begin done = 1; break; end
    end
    bus.trig = 1'b0;
    n_cmp++;
    if (!done) begin n_err++; $display("FAIL tp0_timeout: capture_done got 0 want 1"); end
    n_cmp++;
    if (bus.trace_end !== ADDR_W'(36)) begin
      n_err++; $display("FAIL tp0_trace_end: got %0d want 36", bus.trace_end);
    end
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if ({bus.we, bus.armed, bus.capture_done} !== 3'b001) begin
        n_err++; $display("FAIL tp0_no_post: cycle %0d we/armed/done got %b want 001", i, {bus.we, bus.armed, bus.capture_done});
      end
      @(negedge clk);
    end
    n_cmp++;
    if (nwe != 549) begin n_err++; $display("FAIL tp0_writes: got %0d want 549", nwe); end
  endtask

  // entered in DONE
  task automatic test_dump();
    bus.dump_req = 1'b1;
    @(negedge clk);
    bus.dump_req = 1'b0;
    n_cmp++;
    if ({bus.dump_en, bus.we, bus.capture_done} !== 3'b101) begin
      n_err++; $display("FAIL dump_start: en/we/done got %b want 101", {bus.dump_en, bus.we, bus.capture_done});
    end
    for (int p = 1; p <= 512; p++) begin
      bus.tx_done = 1'b1;
      @(negedge clk);
      bus.tx_done = 1'b0;
      if (p < 512) begin
        n_cmp++;
        if ({bus.dump_en, bus.dump_done, bus.we, bus.capture_done} !== 4'b1001) begin
          n_err++; $display("FAIL dump_run: pulse %0d en/ddone/we/done got %b want 1001", p,
                            {bus.dump_en, bus.dump_done, bus.we, bus.capture_done});
        end
        @(negedge clk);
      end else begin
        n_cmp++;
        if ({bus.dump_en, bus.dump_done, bus.capture_done} !== 3'b010) begin
          n_err++; $display("FAIL dump_end: en/ddone/done got %b want 010", {bus.dump_en, bus.dump_done, bus.capture_done});
        end
      end
    end
    @(negedge clk);
    n_cmp++;
    if (bus.dump_done !== 1'b0) begin n_err++; $display("FAIL dump_done_pulse: got 1 want 0"); end
    bus.dump_req = 1'b1;
    @(negedge clk);
    bus.dump_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (outs() !== {2'b00, bus.cap_addr, bus.trace_end, 4'b0000}) begin
      n_err++; $display("FAIL dump_idle_req_ignored: got %h", outs());
    end
  endtask

  task automatic test_ignored();
    int nwe = 0;
    bit armed_seen = 0, done = 0, saw_dump = 0;
    start_cap(30, 0);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      bus.trig = 1'b0; bus.dump_req = 1'b0; bus.cap_start = 1'b0;
      if (bus.dump_en) saw_dump = 1;
      if (bus.we) begin
        n_cmp++;
        if (bus.cap_addr !== ADDR_W'(nwe)) begin
          n_err++; $display("FAIL ign_addr: write %0d got %0d want %0d", nwe, bus.cap_addr, ADDR_W'(nwe));
        end
        nwe++;
        if (nwe == 5)   bus.dump_req = 1'b1;
        if (nwe == 490) bus.trig = 1'b1;
        if (nwe == 500) bus.cap_start = 1'b1;
      end
      if (bus.armed && !armed_seen) begin
        armed_seen = 1;
        n_cmp++;
        if (nwe != 482) begin n_err++; $display("FAIL ign_armed_at: got %0d want 482", nwe); end
      end
      if (bus.capture_done) begin done = 1; break; end
    end
    bus.trig = 1'b0; bus.dump_req = 1'b0; bus.cap_start = 1'b0;
    n_cmp++;
    if (!done) begin n_err++; $display("FAIL ign_timeout: capture_done got 0 want 1"); end
    n_cmp++;
    if (saw_dump) begin n_err++; $display("FAIL ign_dump_req: dump_en got 1 want 0"); end
    n_cmp++;
    if (nwe != 521) begin n_err++; $display("FAIL ign_writes: got %0d want 521", nwe); end
    n_cmp++;
    if (bus.trace_end !== ADDR_W'(8)) begin
      n_err++; $display("FAIL ign_trace_end: got %0d want 8", bus.trace_end);
    end
    bus.cap_start = 1'b1;
    @(negedge clk);
    bus.cap_start = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus.we, bus.armed, bus.capture_done} !== 3'b001) begin
      n_err++; $display("FAIL ign_done_cap_start: we/armed/done got %b want 001", {bus.we, bus.armed, bus.capture_done});
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_fill();
    test_decimate();
    test_tp0();
    test_dump();
    test_ignored();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
